// File: rtl/multiplier_pkg.sv
// Shared encodings for the shift-add multiplier controller and its accumulator.
// The acc_s codes are also decoded by the accumulator datapath.
package multiplier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] ACC_HOLD  = 2'b00;
  localparam logic [1:0] ACC_LOAD  = 2'b01;
  localparam logic [1:0] ACC_SHIFT = 2'b10;
  localparam logic [1:0] ACC_ADD   = 2'b11;

  // Iteration counter width: ceil(log2(n)), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Counts completed EVAL/SHIFT pairs; last flags the final pair of an operation.
module iter_counter
  import multiplier_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_VAL = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/multiplier_ctrl.sv
// Shift-add multiplier sequencer: one LOAD, then N EVAL/SHIFT pairs, then a DONE pulse.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | accumulator loads operands, iteration count cleared
//   EVAL  | add multiplicand when multiplier LSB is 1
//   SHIFT | shift accumulator right, advance iteration count
//   DONE  | one-cycle completion pulse
module multiplier_ctrl
  import multiplier_pkg::*;
#(
  parameter int WIDTH     = 11,
  parameter int WIDTH_ACC = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       q_lsb,
  output logic       acc_en,
  output logic [1:0] acc_s,
  output logic       busy,
  output logic       done
);

  // WIDTH only sizes the external accumulator; here it is just sanity-checked.
  if (WIDTH < 1 || WIDTH_ACC < 1) begin : g_param_check
    $error("multiplier_ctrl: WIDTH and WIDTH_ACC must be at least 1");
  end

  state_e state_q, state_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

  iter_counter #(
    .N(WIDTH_ACC)
  ) u_iter_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_en  = 1'b0;
    acc_s   = ACC_HOLD;
    busy    = 1'b0;
    done    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        acc_en  = 1'b1;
        acc_s   = ACC_LOAD;
        busy    = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        busy = 1'b1;
        if (q_lsb) begin
          acc_en = 1'b1;
          acc_s  = ACC_ADD;
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        acc_en = 1'b1;
        acc_s  = ACC_SHIFT;
        busy   = 1'b1;
        // Counter stops at N-1 so it never wraps inside one operation.
        if (cnt_last) begin
          state_d = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
          state_d = ST_EVAL;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multiplier_ctrl.sv
// Self-checking bench for multiplier_ctrl against a cycle-phase reference model.
module tb_multiplier_ctrl;

  localparam int N      = 5;
  localparam int DONE_P = 2 * N + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       q_lsb = 1'b0;
  logic       acc_en;
  logic [1:0] acc_s;
  logic       busy;
  logic       done;
  logic [4:0] act_v;
  logic [4:0] exp_v;

  int checks = 0;
  int errors = 0;
  int p = 0;  // model phase: 0 idle, k = k-th cycle after start was accepted

  always #5 clk = ~clk;

  multiplier_ctrl #(.WIDTH(11), .WIDTH_ACC(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .q_lsb (q_lsb),
    .acc_en(acc_en),
    .acc_s (acc_s),
    .busy  (busy),
    .done  (done)
  );

  assign act_v = {acc_en, acc_s, busy, done};

  // Expected {acc_en, acc_s, busy, done} for a given phase of an operation.
  function automatic logic [4:0] model_out(input int ph, input logic q);
    if (ph == 1) return 5'b1_01_1_0;
    if (ph >= 2 && ph <= 2 * N + 1) begin
      if (ph % 2 == 0) return q ? 5'b1_11_1_0 : 5'b0_00_1_0;
      return 5'b1_10_1_0;
    end
    if (ph == DONE_P) return 5'b0_00_0_1;
    return 5'b0_00_0_0;
  endfunction

  function automatic int model_next(input int ph, input logic st, input logic rn);
    if (!rn) return 0;
    if (ph == 0) return st ? 1 : 0;
    if (ph == DONE_P) return 0;
    return ph + 1;
  endfunction

  // Drive one cycle of inputs, compute the expectation, advance the model.
  task automatic tick(input logic st, input logic q, input logic rn);
    @(negedge clk);
    start = st;
    q_lsb = q;
    rst_n = rn;
    #1;
    exp_v = model_out(p, q);
    p = model_next(p, st, rn);
  endtask

  task automatic test_reset;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    checks++;
    if (act_v !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b", act_v, 5'b0);
    end
    tick(1'b0, 1'b1, 1'b1);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL reset_after: got %b want %b", act_v, exp_v);
    end
  endtask

  task automatic test_directed;
    logic       stream [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] exp_s  [11] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11,
                                2'b10, 2'b00, 2'b10, 2'b11, 2'b10};
    int n_done = 0;
    int done_c = -1;
    logic q;
    for (int c = 0; c <= 13; c++) begin
      if (c >= 2 && c <= 11 && c % 2 == 0) q = stream[(c - 2) / 2];
      else q = 1'($urandom);
      tick(c == 0, q, 1'b1);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL directed_model cycle %0d: got %b want %b", c, act_v, exp_v);
      end
      if (c >= 1 && c <= 11) begin
        checks++;
        if (acc_s !== exp_s[c - 1]) begin
          errors++;
          $display("FAIL directed_acc_s cycle %0d: got %b want %b", c, acc_s, exp_s[c - 1]);
        end
      end
      if (done === 1'b1) begin
        n_done++;
        done_c = c;
      end
    end
    checks++;
    if (n_done != 1 || done_c != DONE_P) begin
      errors++;
      $display("FAIL directed_done: got %0d pulses last at %0d want 1 at %0d", n_done, done_c, DONE_P);
    end
  endtask

  task automatic test_q_zero;
    int n_add = 0;
    int done_c = -1;
    for (int c = 0; c <= 13; c++) begin
      tick(c == 0, 1'b0, 1'b1);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL qzero_model cycle %0d: got %b want %b", c, act_v, exp_v);
      end
      if (acc_s === 2'b11) n_add++;
      if (done === 1'b1) done_c = c;
    end
    checks++;
    if (n_add != 0 || done_c != DONE_P) begin
      errors++;
      $display("FAIL qzero_summary: got adds %0d done at %0d want 0 and %0d", n_add, done_c, DONE_P);
    end
  endtask

  task automatic test_ignore_start;
    int n_done = 0;
    int done_c = -1;
    for (int c = 0; c <= 14; c++) begin
      tick(c == 0 || c == 4 || c == 9, 1'($urandom), 1'b1);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL ignore_model cycle %0d: got %b want %b", c, act_v, exp_v);
      end
      if (done === 1'b1) begin
        n_done++;
        done_c = c;
      end
    end
    checks++;
    if (n_done != 1 || done_c != DONE_P) begin
      errors++;
      $display("FAIL ignore_done: got %0d pulses last at %0d want 1 at %0d", n_done, done_c, DONE_P);
    end
  endtask

  task automatic test_reset_mid;
    int n_done = 0;
    int done_c = -1;
    for (int c = 0; c <= 23; c++) begin
      tick(c == 0 || c == 10, 1'($urandom), c != 6);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL rstmid_model cycle %0d: got %b want %b", c, act_v, exp_v);
      end
      if (c >= 7 && c <= 10) begin
        checks++;
        if (act_v !== 5'b0) begin
          errors++;
          $display("FAIL rstmid_idle cycle %0d: got %b want %b", c, act_v, 5'b0);
        end
      end
      if (done === 1'b1) begin
        n_done++;
        done_c = c;
      end
    end
    checks++;
    if (n_done != 1 || done_c != 10 + DONE_P) begin
      errors++;
      $display("FAIL rstmid_done: got %0d pulses last at %0d want 1 at %0d", n_done, done_c, 10 + DONE_P);
    end
  endtask

  task automatic test_back_to_back;
    int done_cs[$];
    for (int c = 0; c <= 40; c++) begin
      tick(c < 30, 1'($urandom), 1'b1);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL b2b_model cycle %0d: got %b want %b", c, act_v, exp_v);
      end
      if (c == 12 || c == 13 || c == 25 || c == 26) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_busy cycle %0d: got %b want 0", c, busy);
        end
      end
      if (done === 1'b1 && c < 30) done_cs.push_back(c);
    end
    checks++;
    if (done_cs.size() != 2 || done_cs[0] != 12 || done_cs[1] != 25) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses first %0d want 12 and 25",
               done_cs.size(), (done_cs.size() > 0) ? done_cs[0] : -1);
    end
  endtask

  task automatic test_random;
    for (int op = 0; op < 8; op++) begin
      int gap = $urandom_range(0, 3);
      int rst_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DONE_P) : -1;
      for (int g = 0; g < gap; g++) begin
        tick(1'b0, 1'($urandom), 1'b1);
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL random_gap op %0d: got %b want %b", op, act_v, exp_v);
        end
      end
      for (int c = 0; c <= DONE_P + 1; c++) begin
        tick(c == 0 || $urandom_range(0, 3) == 0, 1'($urandom), c != rst_at);
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL random_model op %0d cycle %0d: got %b want %b", op, c, act_v, exp_v);
        end
        checks++;
        if (done === 1'b1 && busy === 1'b1) begin
          errors++;
          $display("FAIL random_done_busy op %0d cycle %0d: got done=1 busy=1 want not both", op, c);
        end
      end
      while (p != 0) begin
        tick(1'b0, 1'($urandom), 1'b1);
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL random_drain op %0d: got %b want %b", op, act_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_q_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
